// File: rtl/board_pkg.sv
// Shared encodings for the board-state checkers: cell/result codes, scan FSM states
// and the tic-tac-toe line table.
package board_pkg;

    localparam int unsigned MACRO_CELLS = 9;

    typedef enum logic [1:0] {
        ST_ANDAMENTO = 2'b00,
        ST_P1        = 2'b01,
        ST_P2        = 2'b10,
        ST_EMPATE    = 2'b11
    } cell_st_e;

    typedef enum logic [1:0] {
        S_IDLE,
        S_FETCH,
        S_LAST,
        S_EVAL
    } scan_state_e;

    // Cell numbers (1-based) of the 8 winning lines.
    localparam logic [0:7][0:2][3:0] WIN_LINES = {
        4'd1, 4'd2, 4'd3,
        4'd4, 4'd5, 4'd6,
        4'd7, 4'd8, 4'd9,
        4'd1, 4'd4, 4'd7,
        4'd2, 4'd5, 4'd8,
        4'd3, 4'd6, 4'd9,
        4'd1, 4'd5, 4'd9,
        4'd3, 4'd5, 4'd7
    };

endpackage

// File: rtl/win_line_evaluator.sv
// Combinational game-result evaluation of a 3x3 board: line wins (P1 priority),
// otherwise draw when full, otherwise in progress.
module win_line_evaluator
    import board_pkg::*;
(
    input  logic [MACRO_CELLS:1][1:0] cells,
    output logic [1:0]                result
);

    logic p1_win;
    logic p2_win;
    logic full;

    always_comb begin
        p1_win = 1'b0;
        p2_win = 1'b0;
        full   = 1'b1;
        for (int unsigned l = 0; l < 8; l++) begin
            if (cells[WIN_LINES[l][0]] == ST_P1 && cells[WIN_LINES[l][1]] == ST_P1 &&
                cells[WIN_LINES[l][2]] == ST_P1)
                p1_win = 1'b1;
            if (cells[WIN_LINES[l][0]] == ST_P2 && cells[WIN_LINES[l][1]] == ST_P2 &&
                cells[WIN_LINES[l][2]] == ST_P2)
                p2_win = 1'b1;
        end
        for (int unsigned i = 1; i <= MACRO_CELLS; i++) begin
            if (cells[i] == ST_ANDAMENTO)
                full = 1'b0;
        end

        if (p1_win)
            result = ST_P1;
        else if (p2_win)
            result = ST_P2;
        else if (full)
            result = ST_EMPATE;
        else
            result = ST_ANDAMENTO;
    end

endmodule

// File: rtl/macro_winner_checker.sv
// Scans macro cells 1..CELLS from the registered-read board RAM and registers the
// game result, pulsing done for one cycle when it is updated.
module macro_winner_checker
    import board_pkg::*;
#(
    parameter int unsigned CELLS  = 9,
    parameter int unsigned ADDR_W = 4
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic              start,
    output logic [ADDR_W-1:0] ram_addr,
    input  logic [1:0]        ram_q,
    output logic              busy,
    output logic              done,
    output logic [1:0]        result
);

    scan_state_e             state;
    scan_state_e             state_nxt;
    logic [ADDR_W-1:0]       issue_cnt;
    logic [ADDR_W-1:0]       cap_addr;
    logic [CELLS:1][1:0]     cells;
    logic [1:0]              eval_result;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n)
            state <= S_IDLE;
        else
            state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        unique case (state)
            S_IDLE:  if (start) state_nxt = S_FETCH;
            S_FETCH: if (issue_cnt == ADDR_W'(CELLS)) state_nxt = S_LAST;
            S_LAST:  state_nxt = S_EVAL;
            S_EVAL:  state_nxt = S_IDLE;
            default: state_nxt = S_IDLE;
        endcase
    end

    always_comb begin
        busy     = (state != S_IDLE);
        ram_addr = (state == S_FETCH || state == S_LAST) ? issue_cnt : '0;
    end

    // cap_addr trails ram_addr by one edge to match the RAM's registered read.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            issue_cnt <= '0;
            cap_addr  <= '0;
            cells     <= '0;
        end else begin
            if (state == S_IDLE && start)
                issue_cnt <= ADDR_W'(1);
            else if (state == S_FETCH && issue_cnt != ADDR_W'(CELLS))
                issue_cnt <= issue_cnt + ADDR_W'(1);
            cap_addr <= (state == S_FETCH) ? issue_cnt : '0;
            for (int unsigned k = 1; k <= CELLS; k++) begin
                if (cap_addr == ADDR_W'(k))
                    cells[k] <= ram_q;
            end
        end
    end

    win_line_evaluator u_eval (
        .cells  (cells),
        .result (eval_result)
    );

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            result <= ST_ANDAMENTO;
            done   <= 1'b0;
        end else begin
            done <= (state == S_EVAL);
            if (state == S_EVAL)
                result <= eval_result;
        end
    end

endmodule

// File: doc/macro_winner_checker.md
Name: macro_winner_checker

Overview:
- Downstream consumer of the macro board-state RAM, which holds 10 cells × 2 bits; only cells 1–9 are used.
- On request, scans macro cells 1..9 through the RAM read port and registers the overall game result.
- Evaluates the 8 tic-tac-toe lines and the full-board draw condition.
- Sits between the board-state RAM and the game-control FSM. The game-control FSM pulses start after every macro cell update.

Parameters:
- CELLS, 9, number of macro cells scanned (addresses 1..CELLS).
- ADDR_W, 4, width of the RAM address bus.

Ports:
- clk  input  1  system clock; all state updates on its rising edge.
- reset_n  input  1  asynchronous, active-low reset.
- start  input  1  request a scan; sampled only in IDLE.
- ram_addr  output  ADDR_W  address to the board-state RAM read port.
- ram_q  input  2  RAM read data; valid one cycle after ram_addr is presented, because the RAM registers the address.
- busy  output  1  high while a scan/evaluation is in progress.
- done  output  1  one-cycle pulse when result is updated.
- result  output  2  game result: 00 in progress, 01 player 1 won, 10 player 2 won, 11 draw.

Behaviour:
- Reset (reset_n=0, asynchronous, at any time including mid-scan):
  - State goes to IDLE.
  - ram_addr=0, busy=0, done=0, result=00.
  - All captured cells are cleared to 00.
- Cell encoding matches the RAM: 00 open, 01 P1, 10 P2, 11 drawn cell.
- FSM states:
  - IDLE:
    - ram_addr=0 (unused cell), busy=0.
    - start=1 at edge E0 → FETCH; issue counter = 1.
  - FETCH:
    - ram_addr = issue counter. Addresses 1..9 are driven on consecutive cycles after edges E0..E8.
    - Capture pipeline: ram_q is stored into cell[k] at edge E(k+1), for k=1..9.
    - Once address 9 has been issued, at E9 → LAST.
  - LAST:
    - ram_addr holds 9 (don't-care for the RAM).
    - cell[9] is captured at E10 → EVAL.
  - EVAL:
    - Combinational evaluation of the captured cells.
    - At E11: result is registered, done=1 for exactly the following cycle, → IDLE.
- Latency: start sampled at E0 → done high in the cycle after E11, i.e. 11 clocks. busy is high from after E0 until after E11.
- Evaluation rules:
  - Lines: (1,2,3) (4,5,6) (7,8,9) (1,4,7) (2,5,8) (3,6,9) (1,5,9) (3,5,7).
  - A line is won by P1 if all three cells are 01, and by P2 if all three are 10.
  - 11 cells never contribute to any player's line.
  - If both players own a line (illegal game state), P1 takes priority → 01.
  - No winner and all nine cells ≠ 00 → 11.
  - Otherwise → 00.
- result holds its value between scans; it changes only at the end of EVAL or on reset.
- start while busy is ignored, with no queuing. start held high continuously causes back-to-back scans, with one IDLE cycle between them.
- Cell 0 is never read as data.

Decomposition:
- Shared package (board_pkg):
  - Cell/result encodings: ST_ANDAMENTO=00, ST_P1=01, ST_P2=10, ST_EMPATE=11.
  - MACRO_CELLS=9.
  - FSM state encoding.
  - The 8-entry line index table.
  - This package is reused by the micro-board checker.
- Sub-module win_line_evaluator: purely combinational. Input is 9×2-bit cells; output is the 2-bit result per the rules above. It is reusable later for micro-board evaluation.

Test Plan:
- Board all 00; pulse start → addresses 1..9 appear on consecutive cycles; done 11 cycles after start; result=00.
- Cells 1,2,3=01, others 00 → result=01. Also check that result holds 01 after done, until the next scan.
- Cells 3,5,7=10, cell 1=01 → result=10. Then cells 1,5,9=11, others 00 → result=00 (a drawn-cell line is not a win).
- Full board with no line, e.g. 01,10,01,01,10,10,10,01,11 for cells 1..9 → result=11. Same board with cell 9=00 → result=00.
- RAM at power-on contents (cell2=01, cell5=10, cell7=11) → result=00. Then pulse start again while busy at cycle 4 → ignored, single done pulse.
- Assert reset_n=0 at cycle 5 of a scan whose board has a P1 win → immediately busy=0, done=0, result=00, ram_addr=0. After release, a fresh start yields result=01 normally.
